// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: collects credit in 50-cent units,
// vends at PRICE, waits for the dispenser to acknowledge, then pays out
// change one coin per cycle. Cancel or inactivity refunds the credit.
module vend_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 255,
    parameter int CW         = $clog2(MAX_CREDIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          dispense_ack,
    output logic          dispense,
    output logic          change_pulse,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);

    // Sum must hold credit plus a 4-unit coin without wrapping.
    localparam int SW = (CW + 1 > 3) ? CW + 1 : 3;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] MAXS   = SW'(MAX_CREDIT);
    localparam logic [SW-1:0] PRICES = SW'(PRICE);
    localparam logic [TW-1:0] TLIM   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t         state;
    logic [TW-1:0]  tcnt;
    logic [SW-1:0]  coin_val;
    logic [SW-1:0]  sum;

    // Coin value in units and the tentative new credit.
    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = SW'(1);
            2'b10:   coin_val = SW'(2);
            2'b11:   coin_val = SW'(4);
            default: coin_val = '0;
        endcase
        sum = SW'(credit) + coin_val;
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            tcnt         <= '0;
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel) begin
                        // Cancel wins over a coin in the same cycle.
                        if (coin != 2'b00) coin_reject <= 1'b1;
                        tcnt <= '0;
                        if (credit != '0) begin
                            state <= CHANGE;
                            busy  <= 1'b1;
                        end
                    end else if (coin != 2'b00) begin
                        if (sum > MAXS) begin
                            coin_reject <= 1'b1;
                        end else begin
                            tcnt <= '0;
                            if (sum >= PRICES) begin
                                state    <= VEND;
                                dispense <= 1'b1;
                                busy     <= 1'b1;
                                credit   <= CW'(sum - PRICES);
                            end else begin
                                credit <= CW'(sum);
                            end
                        end
                    end else if (credit == '0) begin
                        tcnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (tcnt == TLIM) begin
                            tcnt  <= '0;
                            state <= CHANGE;
                            busy  <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                VEND: begin
                    if (coin != 2'b00) coin_reject <= 1'b1;
                    if (dispense_ack) begin
                        dispense <= 1'b0;
                        if (credit != '0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    if (coin != 2'b00) coin_reject <= 1'b1;
                    if (credit != '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - CW'(1);
                        // Leave on the same edge as the last coin so busy drops with credit.
                        if (credit == CW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    dispense <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: two instances (PRICE=3 and PRICE=7) share the same
// stimulus; a transaction-level reference model predicts every output.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       dispense_ack = 1'b0;

    logic       disp [2];
    logic       chg  [2];
    logic       rej  [2];
    logic [2:0] cred [2];
    logic       bsy  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE(3), .MAX_CREDIT(7), .TIMEOUT(8)) u0 (
        .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel),
        .dispense_ack(dispense_ack), .dispense(disp[0]), .change_pulse(chg[0]),
        .coin_reject(rej[0]), .credit(cred[0]), .busy(bsy[0])
    );

    vend_ctrl #(.PRICE(7), .MAX_CREDIT(7), .TIMEOUT(8)) u1 (
        .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel),
        .dispense_ack(dispense_ack), .dispense(disp[1]), .change_pulse(chg[1]),
        .coin_reject(rej[1]), .credit(cred[1]), .busy(bsy[1])
    );

    // Reference model: customer-session view of each machine.
    localparam int COLLECTING = 0;
    localparam int VENDING    = 1;
    localparam int REFUNDING  = 2;

    int p_price [2] = '{3, 7};
    int p_max   [2] = '{7, 7};
    int p_tmo   [2] = '{8, 8};
    int units   [4] = '{0, 1, 2, 4};

    int m_credit [2];
    int m_phase  [2];
    int m_idle   [2];
    int m_chg    [2];
    int m_rej    [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_credit[d] = 0; m_phase[d] = COLLECTING; m_idle[d] = 0;
            m_chg[d] = 0; m_rej[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int u;
            u = units[coin];
            m_chg[d] = 0;
            m_rej[d] = 0;
            if (m_phase[d] == COLLECTING) begin
                if (cancel) begin
                    m_rej[d] = (u != 0);
                    m_idle[d] = 0;
                    if (m_credit[d] > 0) m_phase[d] = REFUNDING;
                end else if (u != 0) begin
                    if (m_credit[d] + u > p_max[d]) begin
                        m_rej[d] = 1;
                    end else begin
                        m_idle[d] = 0;
                        m_credit[d] += u;
                        if (m_credit[d] >= p_price[d]) begin
                            m_credit[d] -= p_price[d];
                            m_phase[d] = VENDING;
                        end
                    end
                end else if (m_credit[d] == 0) begin
                    m_idle[d] = 0;
                end else if (p_tmo[d] > 0) begin
                    m_idle[d]++;
                    if (m_idle[d] == p_tmo[d]) begin
                        m_idle[d] = 0;
                        m_phase[d] = REFUNDING;
                    end
                end
            end else if (m_phase[d] == VENDING) begin
                m_rej[d] = (u != 0);
                if (dispense_ack) m_phase[d] = (m_credit[d] > 0) ? REFUNDING : COLLECTING;
            end else begin
                m_rej[d] = (u != 0);
                if (m_credit[d] > 0) begin
                    m_chg[d] = 1;
                    m_credit[d]--;
                end
                if (m_credit[d] == 0) m_phase[d] = COLLECTING;
            end
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d observed=%0d expected=%0d at %0t", tag, d, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, ".dispense"}, d, 32'(disp[d]), 32'(m_phase[d] == VENDING));
            chk({tag, ".change"},   d, 32'(chg[d]),  32'(m_chg[d]));
            chk({tag, ".reject"},   d, 32'(rej[d]),  32'(m_rej[d]));
            chk({tag, ".credit"},   d, 32'(cred[d]), 32'(m_credit[d]));
            chk({tag, ".busy"},     d, 32'(bsy[d]),  32'(m_phase[d] != COLLECTING));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic [1:0] c, input logic can, input logic ack);
        coin = c; cancel = can; dispense_ack = ack;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        set_in(2'b00, 1'b0, 1'b0);
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("reset");

        // 50c x3: credit 1, 2, then vend with no change.
        set_in(2'b01, 0, 0); step("s1.c1");
        chk("s1.credit1", 0, 32'(cred[0]), 32'd1);
        step("s1.c2");
        chk("s1.credit2", 0, 32'(cred[0]), 32'd2);
        step("s1.c3");
        chk("s1.vend", 0, 32'(disp[0]), 32'd1);
        set_in(2'b00, 0, 1); step("s1.ack");
        set_in(2'b00, 0, 0); step("s1.idle");
        chk("s1.nochange", 0, 32'(chg[0]), 32'd0);

        // 2 EUR: vend with one coin of change after ack.
        do_reset("s2.rst");
        set_in(2'b11, 0, 0); step("s2.coin");
        chk("s2.credit", 0, 32'(cred[0]), 32'd1);
        set_in(2'b00, 0, 1); step("s2.ack");
        set_in(2'b00, 0, 0); step("s2.pulse");
        chk("s2.pulse", 0, 32'(chg[0]), 32'd1);
        step("s2.done");
        chk("s2.busy", 0, 32'(bsy[0]), 32'd0);

        // Coin with cancel on the same edge: coin rejected, credit refunded.
        do_reset("s3.rst");
        set_in(2'b01, 0, 0); step("s3.coin");
        set_in(2'b10, 1, 0); step("s3.cancel");
        chk("s3.reject", 0, 32'(rej[0]), 32'd1);
        set_in(2'b00, 0, 0); step("s3.refund");
        step("s3.done");

        // PRICE=7 instance: overflowing coin rejected, credit unchanged.
        do_reset("s4.rst");
        set_in(2'b11, 0, 0); step("s4.c1");
        step("s4.c2");
        chk("s4.reject", 1, 32'(rej[1]), 32'd1);
        chk("s4.hold", 1, 32'(cred[1]), 32'd4);
        set_in(2'b10, 0, 0); step("s4.c3");
        chk("s4.credit6", 1, 32'(cred[1]), 32'd6);

        // Inactivity timeout refunds the held credit.
        do_reset("s5.rst");
        set_in(2'b10, 0, 0); step("s5.coin");
        set_in(2'b00, 0, 0);
        for (int i = 0; i < 11; i++) step("s5.wait");
        chk("s5.empty", 0, 32'(cred[0]), 32'd0);

        // Coin during VEND rejected, then reset while paying change.
        do_reset("s6.rst");
        set_in(2'b11, 0, 0); step("s6.coin");
        set_in(2'b01, 0, 0); step("s6.vendcoin");
        chk("s6.reject", 0, 32'(rej[0]), 32'd1);
        chk("s6.credit", 0, 32'(cred[0]), 32'd1);
        set_in(2'b00, 0, 1); step("s6.ack");
        do_reset("s6.midchange");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] c;
            c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            set_in(c, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rnd.rst");
            else step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
